// File: rtl/cr_axi4s_pkt_arb_if.sv
// cr_axi4s_pkt_arb_if: requester FIFO bundle and downstream stream for the packet arbiter
interface cr_axi4s_pkt_arb_if #(
  parameter int N_REQ       = 4,
  parameter int N_DATA_BITS = 64,
  parameter int GRANT_W     = 2
) ();
  logic [N_REQ-1:0]             req_en;
  logic [N_REQ-1:0]             req_empty;
  logic [N_REQ*N_DATA_BITS-1:0] req_data;
  logic [N_REQ-1:0]             req_tlast;
  logic [N_REQ-1:0]             req_rd;
  logic                         out_tvalid;
  logic [N_DATA_BITS-1:0]       out_tdata;
  logic                         out_tlast;
  logic                         out_tready;
  logic [GRANT_W-1:0]           grant_id;
  logic                         busy;
  logic                         pkt_done;
  modport master (
    input  req_en, req_empty, req_data, req_tlast, out_tready,
    output req_rd, out_tvalid, out_tdata, out_tlast, grant_id, busy, pkt_done
  );
  modport slave (
    output req_en, req_empty, req_data, req_tlast, out_tready,
    input  req_rd, out_tvalid, out_tdata, out_tlast, grant_id, busy, pkt_done
  );
endinterface

// File: rtl/cr_axi4s_pkt_arb.sv
// cr_axi4s_pkt_arb: packet-level round-robin arbiter popping N_REQ show-ahead FIFOs into one registered AXI4-stream output
module cr_axi4s_pkt_arb #(
  parameter int N_REQ       = 4,
  parameter int N_DATA_BITS = 64,
  parameter int GRANT_W     = 2
) (
  input logic               clk,
  input logic               rst_n,
  cr_axi4s_pkt_arb_if.master bus
);
  typedef enum logic {ARB, XFER} state_t;
  state_t                 state_q, state_d;
  logic [GRANT_W-1:0]     rr_ptr_q, rr_ptr_d, grant_q, grant_d, sel, idx;
  logic                   found, pop;
  logic [N_REQ-1:0]       cand, rd;
  logic                   out_tvalid_q, out_tvalid_d, out_tlast_q, out_tlast_d, pkt_done_q, pkt_done_d;
  logic [N_DATA_BITS-1:0] out_tdata_q, out_tdata_d;

  assign cand = bus.req_en & ~bus.req_empty;
  assign pop  = (state_q == XFER) & ~bus.req_empty[grant_q] & (~out_tvalid_q | bus.out_tready);

  // first candidate at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr_q;
    idx   = rr_ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      idx = GRANT_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // read strobe goes only to the granted FIFO
  always_comb begin
    rd          = '0;
    rd[grant_q] = pop;
  end

  // grant held for the whole packet; the tlast pop hands priority to the next requester
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == ARB && found) begin
      state_d = XFER;
      grant_d = sel;
    end else if (pop && bus.req_tlast[grant_q]) begin
      state_d  = ARB;
      rr_ptr_d = (grant_q == GRANT_W'(N_REQ-1)) ? '0 : grant_q + 1'b1;
    end
  end

  // single output register: load on pop, drain on accept, hold under backpressure
  always_comb begin
    out_tvalid_d = pop | (out_tvalid_q & ~bus.out_tready);
    out_tdata_d  = pop ? bus.req_data[grant_q*N_DATA_BITS +: N_DATA_BITS] : out_tdata_q;
    out_tlast_d  = pop ? bus.req_tlast[grant_q] : out_tlast_q;
    pkt_done_d   = out_tvalid_q & bus.out_tready & out_tlast_q;
  end

  // state and output registers; reset drops any partial packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tlast_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      out_tvalid_q <= out_tvalid_d;
      out_tdata_q  <= out_tdata_d;
      out_tlast_q  <= out_tlast_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  assign bus.req_rd     = rd;
  assign bus.out_tvalid = out_tvalid_q;
  assign bus.out_tdata  = out_tdata_q;
  assign bus.out_tlast  = out_tlast_q;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state_q == XFER);
  assign bus.pkt_done   = pkt_done_q;
endmodule

// File: tb/tb_cr_axi4s_pkt_arb.sv
// tb_cr_axi4s_pkt_arb: directed checks of grant order, backpressure, underflow, masking and reset
module tb_cr_axi4s_pkt_arb;
  localparam int NR = 4;
  localparam int NB = 64;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b1;
  always #5 clk = ~clk;

  cr_axi4s_pkt_arb_if #(.N_REQ(NR), .N_DATA_BITS(NB), .GRANT_W(GW)) bus ();
  cr_axi4s_pkt_arb #(.N_REQ(NR), .N_DATA_BITS(NB), .GRANT_W(GW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [NB-1:0] mem [NR][16];
  logic          mlast [NR][16];
  logic [3:0]    wp [NR];
  logic [3:0]    rp [NR];

  // show-ahead FIFO models
  always @(posedge clk)
    for (int i = 0; i < NR; i++)
      if (flush) rp[i] <= wp[i];
      else if (bus.req_rd[i]) rp[i] <= rp[i] + 4'd1;

  always_comb begin
    bus.req_empty = '0;
    bus.req_data  = '0;
    bus.req_tlast = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_empty[i]            = (rp[i] == wp[i]);
      bus.req_data[i*NB +: NB]    = mem[i][rp[i]];
      bus.req_tlast[i]            = mlast[i][rp[i]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NB-1:0] obs_d [256];
  logic          obs_l [256];
  int            obs_c [256];
  int            obs_n = 0;
  int            done_n = 0;
  int            done_c = 0;
  int            rd_n [NR] = '{0, 0, 0, 0};

  // mid-cycle monitor of accepted beats, pops and pkt_done
  always @(negedge clk) begin
    if (bus.out_tvalid && bus.out_tready) begin
      obs_d[obs_n] <= bus.out_tdata;
      obs_l[obs_n] <= bus.out_tlast;
      obs_c[obs_n] <= cyc;
      obs_n        <= obs_n + 1;
    end
    if (bus.pkt_done) begin
      done_n <= done_n + 1;
      done_c <= cyc;
    end
    for (int i = 0; i < NR; i++)
      if (bus.req_rd[i]) rd_n[i] <= rd_n[i] + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] dv(input int r, input int b);
    return 64'hC0DE_0000_0000_0000 | (64'(r) << 32) | 64'(b * 3 + 1);
  endfunction

  task automatic push(input int r, input int b, input logic last);
    mem[r][wp[r]]   = dv(r, b);
    mlast[r][wp[r]] = last;
    wp[r]           = wp[r] + 4'd1;
  endtask

  task automatic push_pkt(input int r, input int n);
    for (int b = 0; b < n; b++) push(r, b, b == n - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_beats(input int n, input string tag);
    int t;
    t = 0;
    while (obs_n < n && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(tag, 64'(obs_n), 64'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b1;
    idle(2);
    flush = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic chk_seq(input int base, input int r, input int nb, input string tag);
    for (int b = 0; b < nb; b++) begin
      chk({tag, "_data"}, obs_d[base+b], dv(r, b));
      chk({tag, "_last"}, 64'(obs_l[base+b]), 64'(b == nb - 1));
    end
  endtask

  int base, d0, r0, pc;

  initial begin
    for (int i = 0; i < NR; i++) wp[i] = 4'd0;
    bus.req_en     = '1;
    bus.out_tready = 1'b1;
    idle(1);
    chk("rst_tvalid", 64'(bus.out_tvalid), 0);
    chk("rst_tdata", bus.out_tdata, 0);
    chk("rst_tlast", 64'(bus.out_tlast), 0);
    chk("rst_rd", 64'(bus.req_rd), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_done", 64'(bus.pkt_done), 0);
    chk("rst_grant", 64'(bus.grant_id), 0);
    chk("rst_rr", 64'(dut.rr_ptr_q), 0);
    idle(1);
    flush = 1'b0;
    rst_n = 1'b1;
    idle(1);

    base = obs_n; d0 = done_n; r0 = rd_n[1]; pc = cyc;
    push_pkt(1, 3);
    wait_beats(base + 3, "t1_beats");
    idle(3);
    chk_seq(base, 1, 3, "t1");
    chk("t1_lat", 64'(obs_c[base] - pc), 2);
    chk("t1_contig", 64'(obs_c[base+2] - obs_c[base]), 2);
    chk("t1_pops", 64'(rd_n[1] - r0), 3);
    chk("t1_done", 64'(done_n - d0), 1);
    chk("t1_done_cyc", 64'(done_c), 64'(obs_c[base+2] + 1));
    chk("t1_rr", 64'(dut.rr_ptr_q), 2);
    chk("t1_busy", 64'(bus.busy), 0);

    do_reset();
    base = obs_n;
    for (int r = 0; r < NR; r++) push_pkt(r, 2);
    wait_beats(base + 8, "t2_beats");
    for (int r = 0; r < NR; r++) begin
      chk_seq(base + 2*r, r, 2, "t2");
      chk("t2_inpkt", 64'(obs_c[base+2*r+1] - obs_c[base+2*r]), 1);
    end
    for (int r = 1; r < NR; r++) chk("t2_bubble", 64'(obs_c[base+2*r] - obs_c[base+2*r-1]), 2);

    do_reset();
    base = obs_n; r0 = rd_n[0];
    push_pkt(0, 4);
    wait_beats(base + 2, "t3_pre");
    bus.out_tready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_valid", 64'(bus.out_tvalid), 1);
      chk("t3_hold", bus.out_tdata, dv(0, 2));
      chk("t3_rd", 64'(bus.req_rd), 0);
    end
    @(posedge clk);
    #1;
    bus.out_tready = 1'b1;
    wait_beats(base + 4, "t3_beats");
    idle(3);
    chk("t3_count", 64'(obs_n), 64'(base + 4));
    chk_seq(base, 0, 4, "t3");
    chk("t3_pops", 64'(rd_n[0] - r0), 4);

    do_reset();
    base = obs_n;
    push(3, 0, 1'b0);
    wait_beats(base + 1, "t4_first");
    push_pkt(0, 2);
    repeat (3) begin
      @(negedge clk);
      chk("t4_busy", 64'(bus.busy), 1);
      chk("t4_grant", 64'(bus.grant_id), 3);
      chk("t4_rd", 64'(bus.req_rd), 0);
    end
    @(posedge clk);
    #1;
    push(3, 1, 1'b0);
    push(3, 2, 1'b0);
    push(3, 3, 1'b1);
    wait_beats(base + 6, "t4_beats");
    chk_seq(base, 3, 4, "t4_r3");
    chk_seq(base + 4, 0, 2, "t4_r0");

    do_reset();
    bus.req_en = 4'b1011;
    base = obs_n; r0 = rd_n[2];
    for (int r = 0; r < NR; r++) push_pkt(r, 2);
    wait_beats(base + 6, "t4m_beats");
    idle(6);
    chk("t4m_count", 64'(obs_n), 64'(base + 6));
    chk("t4m_r2_pops", 64'(rd_n[2] - r0), 0);
    chk("t4m_busy", 64'(bus.busy), 0);
    chk_seq(base, 0, 2, "t4m_r0");
    chk_seq(base + 2, 1, 2, "t4m_r1");
    chk_seq(base + 4, 3, 2, "t4m_r3");
    bus.req_en = '1;

    do_reset();
    base = obs_n;
    push_pkt(1, 4);
    wait_beats(base + 2, "t5_pre");
    rst_n = 1'b0;
    #1;
    chk("t5_tvalid", 64'(bus.out_tvalid), 0);
    chk("t5_tdata", bus.out_tdata, 0);
    chk("t5_tlast", 64'(bus.out_tlast), 0);
    chk("t5_rd", 64'(bus.req_rd), 0);
    chk("t5_busy", 64'(bus.busy), 0);
    chk("t5_grant", 64'(bus.grant_id), 0);
    chk("t5_state", 64'(dut.state_q), 0);
    chk("t5_rr", 64'(dut.rr_ptr_q), 0);
    do_reset();
    base = obs_n;
    push_pkt(1, 2);
    push_pkt(0, 2);
    wait_beats(base + 4, "t5_beats");
    chk_seq(base, 0, 2, "t5_r0");
    chk_seq(base + 2, 1, 2, "t5_r1");

    do_reset();
    base = obs_n; d0 = done_n;
    push_pkt(0, 1);
    push_pkt(3, 1);
    wait_beats(base + 2, "t6_beats");
    idle(3);
    chk_seq(base, 0, 1, "t6_r0");
    chk_seq(base + 1, 3, 1, "t6_r3");
    chk("t6_done", 64'(done_n - d0), 2);
    chk("t6_grant", 64'(bus.grant_id), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
